// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dmem_state_e;

  // Load data returned when a transaction is aborted by the timeout.
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_ctrl_if.sv
// LSU-side and RAM-side signals of the data-memory controller.
// err_o exists only when DMEM_TIMEOUT_EN is defined.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_gnt_o;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              lsu_rvalid_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
`ifdef DMEM_TIMEOUT_EN
  logic              err_o;
`endif

  // Controller side.
  modport master (
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output lsu_gnt_o, lsu_rdata_o, lsu_rvalid_o, stall_o,
`ifdef DMEM_TIMEOUT_EN
    output err_o,
`endif
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // LSU + RAM environment side.
  modport slave (
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  lsu_gnt_o, lsu_rdata_o, lsu_rvalid_o, stall_o,
`ifdef DMEM_TIMEOUT_EN
    input  err_o,
`endif
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller between the LSU and the data RAM.
// Optional abort-on-timeout when DMEM_TIMEOUT_EN is defined.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic         clock,
  input logic         reset,
  dmem_ctrl_if.master bus
);

  dmem_state_e state_q, state_d;
  logic        accept, done, timeout;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    done          = 1'b0;
    timeout       = 1'b0;
    bus.lsu_gnt_o = (state_q == IDLE);
    bus.stall_o   = (state_q != IDLE) | bus.lsu_req_i;
    case (state_q)
      IDLE: if (bus.lsu_req_i) begin
        accept  = 1'b1;
        state_d = REQ;
      end
      REQ:  if (bus.mem_gnt_i) state_d = WAIT;
      WAIT: if (bus.mem_rvalid_i) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DMEM_TIMEOUT_EN
    // A response arriving on the last allowed cycle still completes normally.
    if (state_q != IDLE && !done && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_req_o    <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_wdata_o  <= '0;
      bus.lsu_rvalid_o <= 1'b0;
      bus.lsu_rdata_o  <= '0;
    end else begin
      bus.lsu_rvalid_o <= done | timeout;
      if (accept) begin
        bus.mem_req_o   <= 1'b1;
        bus.mem_we_o    <= bus.lsu_we_i;
        bus.mem_addr_o  <= bus.lsu_addr_i & ~ADDR_W'(3);
        bus.mem_wdata_o <= bus.lsu_wdata_i;
      end else if (state_q == REQ && (bus.mem_gnt_i || timeout)) begin
        bus.mem_req_o <= 1'b0;
      end
      // mem_we_o stays valid through WAIT and tells us whether this was a load.
      if (done && !bus.mem_we_o)    bus.lsu_rdata_o <= bus.mem_rdata_i;
      if (timeout && !bus.mem_we_o) bus.lsu_rdata_o <= DATA_W'(DMEM_ERR_DATA);
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      bus.err_o <= 1'b0;
    end else begin
      bus.err_o <= timeout;
      if (accept)                tmo_cnt_q <= '0;
      else if (state_q != IDLE)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model (latency = gnt delay + rvalid delay + 3).
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus();
  dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clock(clk), .reset(rst), .bus(bus));

  int checks = 0;
  int passed = 0;
  logic [31:0] last_load;   // model of lsu_rdata_o

  // observations from one transaction
  int          o_lat, o_req, o_unstable, o_hs, o_err;
  logic [31:0] o_addr;

  // Called at a negedge. Request is presented in "cycle 0"; the RAM slave grants
  // after gdly REQ cycles and responds after rdly WAIT cycles. Returns at the
  // negedge of the cycle where lsu_rvalid_o is seen (o_lat = that cycle index).
  task automatic run_txn(input logic we, input logic [31:0] addr, wdata, rdata,
                         input int gdly, rdly, input bit noise);
    logic [31:0] ea;
    int  wcnt;
    bit  granted, resp;
    ea = addr & ~32'h3;
    wcnt = 0; granted = 0; resp = 0;
    o_lat = 0; o_req = 0; o_unstable = 0; o_hs = 0; o_err = 0; o_addr = '0;
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = we; bus.lsu_addr_i = addr; bus.lsu_wdata_i = wdata;
    #1;
    if (bus.stall_o !== 1'b1 || bus.lsu_gnt_o !== 1'b1) o_hs++;
    @(posedge clk); #1;
    bus.lsu_req_i = 1'b0;
    bus.lsu_we_i = 1'($urandom); bus.lsu_addr_i = $urandom; bus.lsu_wdata_i = $urandom;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.lsu_rvalid_o === 1'b1) begin
        o_lat = c;
`ifdef DMEM_TIMEOUT_EN
        o_err = int'(bus.err_o);
`endif
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.lsu_req_i = 1'b0;
        break;
      end
      if (bus.stall_o !== 1'b1 || bus.lsu_gnt_o !== 1'b0) o_hs++;
      bus.mem_gnt_i    = noise ? 1'($urandom) : 1'b0;
      bus.mem_rvalid_i = noise ? 1'($urandom) : 1'b0;
      bus.lsu_req_i    = noise ? 1'($urandom) : 1'b0;
      bus.mem_rdata_i  = $urandom;
      if (!granted) begin
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== ea || bus.mem_we_o !== we ||
            bus.mem_wdata_o !== wdata) o_unstable++;
        if (o_req == 0) o_addr = bus.mem_addr_o;
        bus.mem_gnt_i = (o_req == gdly);
        if (o_req == gdly) granted = 1;
        o_req++;
      end else begin
        if (bus.mem_req_o !== 1'b0) o_unstable++;
        if (!resp) begin
          bus.mem_rvalid_i = (wcnt == rdly);
          if (wcnt == rdly) begin
            resp = 1;
            bus.mem_rdata_i = rdata;
          end
          wcnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_addr_i = 32'h55; bus.lsu_wdata_i = 32'h77;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h99;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.lsu_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    last_load = '0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.lsu_rvalid_o} !== 3'b000)
      $display("FAIL reset_ctl: got %b want 000", {bus.mem_req_o, bus.mem_we_o, bus.lsu_rvalid_o});
    else passed++;
    checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.lsu_rdata_o} !== 96'h0)
      $display("FAIL reset_data: got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o, bus.lsu_rdata_o});
    else passed++;
    checks++;
    if ({bus.lsu_gnt_o, bus.stall_o} !== 2'b10)
      $display("FAIL reset_gnt_stall: got %b want 10", {bus.lsu_gnt_o, bus.stall_o});
    else passed++;
  endtask

  task automatic test_load_zero_delay();
    run_txn(1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    last_load = 32'hCAFE_F00D;
    checks++;
    if (o_lat !== 3) $display("FAIL load_latency: got %0d want 3", o_lat); else passed++;
    checks++;
    if (o_req !== 1 || o_unstable !== 0 || o_addr !== 32'h100)
      $display("FAIL load_bus: req_cycles %0d unstable %0d addr %h want 1 0 00000100", o_req, o_unstable, o_addr);
    else passed++;
    checks++;
    if (o_hs !== 0) $display("FAIL load_stall: bad cycles %0d want 0", o_hs); else passed++;
    checks++;
    if (bus.lsu_rdata_o !== last_load) $display("FAIL load_rdata: got %h want %h", bus.lsu_rdata_o, last_load);
    else passed++;
    #1;
    checks++;
    if ({bus.stall_o, bus.lsu_gnt_o} !== 2'b01)
      $display("FAIL load_idle: stall/gnt %b want 01", {bus.stall_o, bus.lsu_gnt_o});
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.lsu_rvalid_o !== 1'b0) $display("FAIL load_pulse_width: got %b want 0", bus.lsu_rvalid_o); else passed++;
  endtask

  task automatic test_store_delayed_gnt();
    run_txn(1'b1, 32'h204, 32'h1234_5678, 32'hBAD0_BAD0, 3, 1, 1'b0);
    checks++;
    if (o_req !== 4 || o_unstable !== 0)
      $display("FAIL store_req_hold: req_cycles %0d unstable %0d want 4 0", o_req, o_unstable);
    else passed++;
    checks++;
    if (o_lat !== 7) $display("FAIL store_latency: got %0d want 7", o_lat); else passed++;
    checks++;
    if (bus.lsu_rdata_o !== last_load) $display("FAIL store_rdata_kept: got %h want %h", bus.lsu_rdata_o, last_load);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 32'h40, 32'h0, 32'h0BAD_CAFE, 0, 0, 1'b0);
    last_load = 32'h0BAD_CAFE;
    run_txn(1'b1, 32'h44, 32'hA5A5_5A5A, 32'h1, 0, 0, 1'b0);
    checks++;
    if (o_hs !== 0 || o_lat !== 3 || o_req !== 1)
      $display("FAIL b2b_accept: hs %0d lat %0d req %0d want 0 3 1", o_hs, o_lat, o_req);
    else passed++;
    checks++;
    if (bus.lsu_rdata_o !== last_load) $display("FAIL b2b_rdata: got %h want %h", bus.lsu_rdata_o, last_load);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'h300;
    @(posedge clk); #1 bus.lsu_req_i = 1'b0;
    @(negedge clk); bus.mem_gnt_i = 1'b1;
    @(posedge clk); #1 bus.mem_gnt_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_load = '0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.lsu_rvalid_o, bus.mem_addr_o, bus.lsu_rdata_o} !== 67'h0)
      $display("FAIL rst_wait_outputs: req %b addr %h rdata %h want all zero", bus.mem_req_o, bus.mem_addr_o, bus.lsu_rdata_o);
    else passed++;
    checks++;
    if (bus.lsu_gnt_o !== 1'b1) $display("FAIL rst_wait_gnt: got %b want 1", bus.lsu_gnt_o); else passed++;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      if (bus.lsu_rvalid_o !== 1'b0 || bus.lsu_rdata_o !== last_load) bad++;
    end
    bus.mem_rvalid_i = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL rst_wait_late_rvalid: bad cycles %0d want 0", bad); else passed++;
  endtask

  task automatic test_addr_align();
    run_txn(1'b0, 32'h103, 32'h0, 32'h1357_9BDF, 1, 0, 1'b0);
    last_load = 32'h1357_9BDF;
    checks++;
    if (o_addr !== 32'h100 || o_unstable !== 0)
      $display("FAIL addr_align: got %h unstable %0d want 00000100 0", o_addr, o_unstable);
    else passed++;
  endtask

  task automatic test_random();
    int bad_lat, bad_bus, bad_data, bad_idle;
    logic        we;
    logic [31:0] a, wd, rd;
    int          g, r;
    bad_lat = 0; bad_bus = 0; bad_data = 0; bad_idle = 0;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); a = $urandom; wd = $urandom; rd = $urandom;
      g = int'($urandom_range(0, 4)); r = int'($urandom_range(0, 4));
      run_txn(we, a, wd, rd, g, r, 1'b1);
      if (!we) last_load = rd;
      if (o_lat != g + r + 3) bad_lat++;
      if (o_req != g + 1 || o_unstable != 0 || o_hs != 0) bad_bus++;
      if (bus.lsu_rdata_o !== last_load) bad_data++;
      // optional idle gap; otherwise next request lands in the rvalid cycle
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        if (bus.lsu_rvalid_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.lsu_rdata_o !== last_load) bad_idle++;
      end
    end
    checks++;
    if (bad_lat !== 0) $display("FAIL rand_latency: bad %0d want 0", bad_lat); else passed++;
    checks++;
    if (bad_bus !== 0) $display("FAIL rand_bus: bad %0d want 0", bad_bus); else passed++;
    checks++;
    if (bad_data !== 0) $display("FAIL rand_rdata: bad %0d want 0", bad_data); else passed++;
    checks++;
    if (bad_idle !== 0) $display("FAIL rand_idle: bad %0d want 0", bad_idle); else passed++;
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    run_txn(1'b0, 32'h500, 32'h0, 32'h0, 1000, 0, 1'b0);
    last_load = DMEM_ERR_DATA;
    checks++;
    if (o_lat !== 17 || o_req !== 16) $display("FAIL timeout_latency: lat %0d req %0d want 17 16", o_lat, o_req);
    else passed++;
    checks++;
    if (o_err !== 1 || bus.lsu_rdata_o !== last_load)
      $display("FAIL timeout_err: err %0d rdata %h want 1 %h", o_err, bus.lsu_rdata_o, last_load);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.err_o, bus.mem_req_o, bus.lsu_gnt_o} !== 3'b001)
      $display("FAIL timeout_idle: err/req/gnt %b want 001", {bus.err_o, bus.mem_req_o, bus.lsu_gnt_o});
    else passed++;
  endtask
`endif

  initial begin
    bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = '0; bus.lsu_wdata_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    last_load = '0;
    test_reset();
    test_load_zero_delay();
    test_store_delayed_gnt();
    test_back_to_back();
    test_reset_mid_wait();
    @(negedge clk);
    test_addr_align();
    test_random();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory bus controller directly downstream of the load/store unit.
- Accepts one word request (load or store) from the LSU and runs a req/gnt/rvalid handshake with the data RAM.
- Returns load data to decode with a one-cycle valid pulse, and stalls the core while a transaction is outstanding.
- Also produces the grant that enables the LSU: one outstanding transaction, no pipelining.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, cycles in REQ+WAIT before abort. Used only with DMEM_TIMEOUT_EN.

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- lsu_req_i  in  1  valid request from LSU (LSU data_req).
- lsu_we_i  in  1  1 = store (SW), 0 = load (LW).
- lsu_addr_i  in  ADDR_W  word-aligned byte address.
- lsu_wdata_i  in  DATA_W  store data.
- lsu_gnt_o  out  1  controller idle and able to accept; drives LSU data_gnt.
- lsu_rdata_o  out  DATA_W  load data to decode.
- lsu_rvalid_o  out  1  one-cycle pulse: transaction complete (load data valid, or store acked).
- stall_o  out  1  freeze PC/pipeline.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  ADDR_W  bus address, bits [1:0] forced to 00.
- mem_wdata_o  out  DATA_W  bus write data.
- mem_gnt_i  in  1  bus accepted request this cycle.
- mem_rvalid_i  in  1  response valid (read data or write ack).
- mem_rdata_i  in  DATA_W  read data.
- err_o  out  1  timeout pulse. Present only with DMEM_TIMEOUT_EN.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Values after the reset edge: state IDLE; mem_req_o, mem_we_o, lsu_rvalid_o, err_o = 0; mem_addr_o, mem_wdata_o, lsu_rdata_o = 0.
  - Reset mid-transaction abandons it. mem_req_o is 0 from the cycle after the reset edge.
  - Any later mem_rvalid_i is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - lsu_gnt_o = 1, combinational from state only.
  - When lsu_req_i = 1: register addr (with [1:0] zeroed), we and wdata onto the mem_* outputs, set mem_req_o = 1, go to REQ.
- REQ:
  - mem_req_o = 1; addr, we and wdata held stable until grant.
  - When mem_gnt_i = 1: clear mem_req_o, go to WAIT.
  - mem_rvalid_i in REQ is ignored.
  - lsu_req_i is ignored in REQ and WAIT.
- WAIT:
  - When mem_rvalid_i = 1: go to IDLE and pulse lsu_rvalid_o for exactly one cycle (the first IDLE cycle).
  - On a load, lsu_rdata_o <= mem_rdata_i. On a store, lsu_rdata_o is unchanged.
- lsu_rdata_o holds the last load value until the next load completes.
- lsu_gnt_o = (state == IDLE).
- stall_o = (state != IDLE) | (state == IDLE & lsu_req_i). Combinational.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the next cycle:
  - request accepted at edge 0;
  - mem_req_o high in cycle 1;
  - WAIT in cycle 2;
  - lsu_rvalid_o in cycle 3.
- Back-to-back: a new request may be accepted in the same IDLE cycle where lsu_rvalid_o pulses.
- mem_gnt_i outside REQ is ignored.
- mem_rvalid_i outside WAIT is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to REQ and increments every REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no completion: go to IDLE, drop mem_req_o, pulse err_o one cycle, pulse lsu_rvalid_o, and on a load set lsu_rdata_o = 32'hDEAD_BEEF.
  - Completion in the same cycle as timeout takes priority: normal completion, no err_o.
- Undefined: no counter and no err_o port; WAIT may last indefinitely.

Decomposition:
- CORE_PKG gains:
  - typedef enum logic [1:0] dmem_state_e {IDLE, REQ, WAIT};
  - localparam DMEM_ERR_DATA = 32'hDEAD_BEEF.
- Reuse load_store_func_code; the LSU-side decode of LW/SW to lsu_we_i stays in the LSU.
- No sub-module. The timeout counter is inline under the macro.

Test Plan:
- Load, zero bus delay: reset, lsu_req_i=1, we=0, addr=0x100; mem_gnt_i=1 first REQ cycle; rvalid next cycle with rdata 0xCAFE_F00D.
  -> mem_addr_o=0x100, mem_we_o=0; lsu_rvalid_o pulse in cycle 3; lsu_rdata_o=0xCAFE_F00D; stall_o high cycles 0-2.
- Store, grant delayed 3 cycles: we=1, addr=0x204, wdata=0x1234_5678.
  -> mem_req_o high 4 cycles with addr/wdata stable; lsu_rvalid_o pulses after rvalid; lsu_rdata_o unchanged.
- Back-to-back load then store: second lsu_req_i asserted in the lsu_rvalid_o cycle -> accepted there; mem_req_o high again next cycle.
- Reset mid-WAIT: reset after grant, then rvalid=1 two cycles later -> no lsu_rvalid_o; all outputs 0; lsu_gnt_o=1.
- Address bits: lsu_addr_i=0x103 -> mem_addr_o=0x100.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, load, no gnt -> at REQ cycle 16: err_o=1, lsu_rvalid_o=1, lsu_rdata_o=0xDEAD_BEEF, state IDLE.
